// File: rtl/rfarb_pkg.sv
// ---------------------------------------------------------------------------
// rfarb_pkg
// Shared definitions for the register-file arbiter:
//   - rfarb_state_e : access sequencer states
//   - ID_A / ID_B   : requester identifiers (A = CPU, B = debug/IO)
//   - DW_DEF / AW_DEF / NUM_REGS_DEF : default data width, address width and
//     number of implemented register-file entries
// ---------------------------------------------------------------------------
package rfarb_pkg;

    localparam int DW_DEF       = 8;
    localparam int AW_DEF       = 8;
    localparam int NUM_REGS_DEF = 32;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } rfarb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way arbiter producing a one-hot (or zero) grant vector.
// Configuration macro: RF_ARB_ROUND_ROBIN_EN
//   defined : round-robin; on a tie the requester not granted last wins.
//             The priority pointer moves only when 'advance' is high.
//   absent  : fixed priority, req[0] always beats req[1]; no state at all.
// Ports:
//   clk, reset : clock / synchronous active-high reset (round-robin only)
//   advance    : a grant from gnt is being taken this cycle (round-robin only)
//   req[1:0]   : request vector (bit 0 = A, bit 1 = B)
//   gnt[1:0]   : grant vector, combinational from req and the pointer
// ---------------------------------------------------------------------------
module rr_arbiter2 (
`ifdef RF_ARB_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef RF_ARB_ROUND_ROBIN_EN
    // prio_b = 1 means B wins the next tie. Reset favours A.
    logic prio_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_b <= 1'b0;
        end else if (advance) begin
            // Whoever wins now yields the next tie to the other side.
            prio_b <= gnt[0];
        end
    end

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | ~prio_b);
        gnt[1] = req[1] & (~req[0] |  prio_b);
    end
`else
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0];
        gnt[1] = req[1] & ~req[0];
    end
`endif

endmodule

// File: rtl/regfile_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_arbiter
// Arbitrates two requesters (A = CPU, B = debug/IO) onto one single-port
// register file. Exactly one access is in flight; every access (read, write
// or out-of-range) walks IDLE -> ISSUE -> CAPTURE -> DONE, so done appears
// three cycles after the grant cycle.
// Configuration macro: RF_ARB_ROUND_ROBIN_EN (round-robin tie break when
// defined, fixed priority A over B otherwise).
//
// Handshake: a requester raises x_req with x_we/x_addr/x_wdata valid. x_grant
// is high for one cycle (the IDLE cycle) when the request is taken; the fields
// are sampled on the edge that ends that cycle and may change afterwards.
// x_done pulses for one cycle when the access completes; x_err and rdata are
// valid in that same cycle. A req still high after done is arbitrated anew.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   a_/b_req, we, addr, wdata : requester inputs
//   a_/b_grant, done, err : requester outputs (one-cycle pulses)
//   rdata                 : read result, holds until the next read capture
//   rf_address, rf_data_in, rf_enable : registered register-file controls
//   rf_data_out           : register-file read data (one posedge latency)
//   dbg_state             : current sequencer state
// ---------------------------------------------------------------------------
module regfile_arbiter
    import rfarb_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          a_grant,
    output logic          b_grant,
    output logic          a_done,
    output logic          b_done,
    output logic          a_err,
    output logic          b_err,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] rf_address,
    output logic [DW-1:0] rf_data_in,
    output logic          rf_enable,
    input  logic [DW-1:0] rf_data_out,
    output rfarb_state_e  dbg_state
);

    // One extra bit so NUM_REGS == 2**AW still compares correctly.
    localparam logic [AW:0] NUM_REGS_W = (AW+1)'(NUM_REGS);

    rfarb_state_e state_q;
    rfarb_state_e state_d;

    logic          id_q;
    logic          we_q;
    logic          err_q;

    logic [1:0]    arb_gnt;
    logic          grant_fire;
    logic          win_id;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          win_in_range;

    assign grant_fire = (state_q == IDLE) && (a_req || b_req) && !reset;

    rr_arbiter2 u_arb (
`ifdef RF_ARB_ROUND_ROBIN_EN
        .clk     (clk),
        .reset   (reset),
        .advance (grant_fire),
`endif
        .req     ({b_req, a_req}),
        .gnt     (arb_gnt)
    );

    // Winner's request fields, muxed once so the latch logic below is shared.
    always_comb begin
        win_id       = arb_gnt[1] ? ID_B : ID_A;
        win_we       = arb_gnt[1] ? b_we    : a_we;
        win_addr     = arb_gnt[1] ? b_addr  : a_addr;
        win_wdata    = arb_gnt[1] ? b_wdata : a_wdata;
        win_in_range = ({1'b0, win_addr} < NUM_REGS_W);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_fire) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            id_q       <= ID_A;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            rf_address <= '0;
            rf_data_in <= '0;
            rf_enable  <= 1'b0;
            rdata      <= '0;
        end else begin
            state_q <= state_d;

            // rf_enable is set only on the IDLE->ISSUE edge, so it is high
            // for exactly the ISSUE cycle and cleared on the next edge.
            rf_enable <= grant_fire && win_we && win_in_range;

            if (grant_fire) begin
                id_q  <= win_id;
                we_q  <= win_we;
                err_q <= !win_in_range;
                // Out-of-range accesses leave the register-file bus untouched.
                if (win_in_range) begin
                    rf_address <= win_addr;
                    rf_data_in <= win_wdata;
                end
            end

            // rf_data_out reflects rf_address (set entering ISSUE) during
            // CAPTURE; take it on the edge that leaves CAPTURE.
            if ((state_q == CAPTURE) && !we_q && !err_q) begin
                rdata <= rf_data_out;
            end
        end
    end

    always_comb begin
        a_grant   = grant_fire && arb_gnt[0];
        b_grant   = grant_fire && arb_gnt[1];
        a_done    = (state_q == DONE) && (id_q == ID_A);
        b_done    = (state_q == DONE) && (id_q == ID_B);
        a_err     = a_done && err_q;
        b_err     = b_done && err_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_arbiter
// Directed bench for regfile_arbiter with a behavioural register file:
// writes commit on the negedge while rf_enable is high, rf_data_out follows
// rf_address one posedge later.
// ---------------------------------------------------------------------------
module tb_regfile_arbiter;
    import rfarb_pkg::*;

    logic       clk;
    logic       reset;
    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_grant, b_grant, a_done, b_done, a_err, b_err;
    logic [7:0] rdata, rf_address, rf_data_in, rf_data_out;
    logic       rf_enable;
    rfarb_state_e dbg_state;

    logic [7:0] rf_mem [0:255];
    logic [1:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 0;

    regfile_arbiter #(.DW(8), .AW(8), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_grant(a_grant), .b_grant(b_grant),
        .a_done(a_done), .b_done(b_done),
        .a_err(a_err), .b_err(b_err),
        .rdata(rdata),
        .rf_address(rf_address), .rf_data_in(rf_data_in), .rf_enable(rf_enable),
        .rf_data_out(rf_data_out),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- register-file model ----------------
    always @(negedge clk) if (rf_enable) rf_mem[rf_address] <= rf_data_in;
    always @(posedge clk) rf_data_out <= rf_mem[rf_address];

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- continuous protocol monitor ----------------
    logic prev_ag = 0, prev_bg = 0, prev_ad = 0, prev_bd = 0;
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            check_val("a_grant_pulse", {31'd0, a_grant & prev_ag}, 0);
            check_val("b_grant_pulse", {31'd0, b_grant & prev_bg}, 0);
            check_val("a_done_pulse",  {31'd0, a_done & prev_ad}, 0);
            check_val("b_done_pulse",  {31'd0, b_done & prev_bd}, 0);
            check_val("rf_en_outside_issue", {31'd0, rf_enable & (dbg_state != ISSUE)}, 0);
            check_val("both_done",     {31'd0, a_done & b_done}, 0);
            check_val("grant_with_done", {31'd0, (a_grant | b_grant) & (a_done | b_done)}, 0);
        end
        prev_ag = a_grant;
        prev_bg = b_grant;
        prev_ad = a_done;
        prev_bd = b_done;
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    endtask

    // One complete access from a single requester. Grant is expected in the
    // cycle the request is raised (bench always starts from IDLE), done three
    // cycles later.
    task automatic do_access(input bit use_b, input bit we, input logic [7:0] addr,
                             input logic [7:0] wdata, input bit exp_err,
                             input logic [7:0] exp_rdata, output bit en_seen);
        int n;
        logic grant, other_grant, done, other_done, err;
        en_seen = 0;
        @(negedge clk);
        if (use_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
        else       begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
        #1;
        n = 0;
        while (!(use_b ? b_grant : a_grant) && n < 10) begin
            @(negedge clk); #1; n++;
        end
        grant       = use_b ? b_grant : a_grant;
        other_grant = use_b ? a_grant : b_grant;
        check_val("grant_latency", n, 0);
        check_val("grant_seen", {31'd0, grant}, 1);
        check_val("other_grant", {31'd0, other_grant}, 0);
        // After grant the fields are scrambled to prove they were latched.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if (use_b) begin b_req = 0; b_addr = 8'hEE; b_wdata = 8'h13; b_we = ~we; end
                else       begin a_req = 0; a_addr = 8'hEE; a_wdata = 8'h13; a_we = ~we; end
            end
            #1;
            en_seen = en_seen | rf_enable;
            done = use_b ? b_done : a_done;
            if (c < 2) check_val("done_early", {31'd0, done}, 0);
        end
        other_done = use_b ? a_done : b_done;
        err        = use_b ? b_err : a_err;
        check_val("done_at_grant_plus3", {31'd0, done}, 1);
        check_val("other_done", {31'd0, other_done}, 0);
        check_val("err", {31'd0, err}, {31'd0, exp_err});
        check_val("rdata", {24'd0, rdata}, {24'd0, exp_rdata});
        idle_inputs();
    endtask

    // ---------------- main sequence ----------------
    bit en_seen;
    logic [1:0] got_g, exp_g;

    initial begin
        idle_inputs();
        reset = 1;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
        check_val("rst_grants", {30'd0, a_grant, b_grant}, 0);
        check_val("rst_done_err", {28'd0, a_done, b_done, a_err, b_err}, 0);
        check_val("rst_rf_enable", {31'd0, rf_enable}, 0);
        check_val("rst_rf_address", {24'd0, rf_address}, 0);
        check_val("rst_rf_data_in", {24'd0, rf_data_in}, 0);
        check_val("rst_rdata", {24'd0, rdata}, 0);
        @(negedge clk);
        reset = 0;
        mon_en = 1;

        // A writes 0x7F to reg 2 then reads it back.
        do_access(0, 1, 8'd2, 8'h7F, 0, 8'h00, en_seen);
        check_val("wr2_rf_enable_seen", {31'd0, en_seen}, 1);
        do_access(0, 0, 8'd2, 8'h00, 0, 8'h7F, en_seen);
        check_val("rd2_rf_enable_seen", {31'd0, en_seen}, 0);

        // A writes 0x55 to the last implemented reg, B reads it.
        do_access(0, 1, 8'd31, 8'h55, 0, 8'h7F, en_seen);
        do_access(1, 0, 8'd31, 8'h00, 0, 8'h55, en_seen);

        // Both request together and hold: A reads reg 2, B reads reg 31.
`ifdef RF_ARB_ROUND_ROBIN_EN
        exp_q.push_back(2'b01); exp_q.push_back(2'b10); exp_q.push_back(2'b01);
`else
        exp_q.push_back(2'b01); exp_q.push_back(2'b01); exp_q.push_back(2'b01);
`endif
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 8'd2;
        b_req = 1; b_we = 0; b_addr = 8'd31;
        #1;
        for (int g = 0; g < 3; g++) begin
            int n = 0;
            while (!(a_grant || b_grant) && n < 10) begin
                @(negedge clk); #1; n++;
            end
            got_g = {b_grant, a_grant};
            exp_g = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
            check_val("tie_grant_order", {30'd0, got_g}, {30'd0, exp_g});
            repeat (3) begin @(negedge clk); #1; end
            check_val("tie_done", {30'd0, b_done, a_done}, {30'd0, exp_g});
            check_val("tie_rdata", {24'd0, rdata}, (exp_g == 2'b10) ? 32'h55 : 32'h7F);
            if (g < 2) begin
                @(negedge clk); #1;
            end else begin
                idle_inputs();
            end
        end

        // Out-of-range accesses: first invalid address and a far one.
        do_access(1, 0, 8'd40, 8'h00, 1, 8'h7F, en_seen);
        check_val("oor40_rf_enable_seen", {31'd0, en_seen}, 0);
        do_access(0, 1, 8'd32, 8'hAA, 1, 8'h7F, en_seen);
        check_val("oor32_rf_enable_seen", {31'd0, en_seen}, 0);

        // Reset during CAPTURE of an A read aborts it silently.
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 8'd31;
        #1;
        check_val("abort_grant", {31'd0, a_grant}, 1);
        @(negedge clk);
        a_req = 0;
        @(negedge clk);
        reset = 1;
        #1;
        check_val("abort_in_capture", {30'd0, dbg_state}, {30'd0, CAPTURE});
        @(negedge clk);
        reset = 0;
        #1;
        check_val("abort_state_idle", {30'd0, dbg_state}, {30'd0, IDLE});
        check_val("abort_outputs", {26'd0, a_grant, b_grant, a_done, b_done, a_err, b_err}, 0);
        check_val("abort_rdata", {24'd0, rdata}, 0);
        check_val("abort_rf_bus", {15'd0, rf_enable, rf_address, rf_data_in}, 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            check_val("abort_no_done", {30'd0, a_done, a_err}, 0);
        end

        // Register contents survive reset.
        do_access(0, 0, 8'd31, 8'h00, 0, 8'h55, en_seen);

        repeat (3) @(negedge clk);
        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
